hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Central pipeline sequencer for the 5-stage RV32IM core.
- Generates enable/flush controls for PC, IF/ID, ID/EX and EX/MEM registers from three hazard sources: load-use (data), taken branch/jump redirect (control), and multi-cycle MUL/DIV occupancy (structural).
- Instruction memory output is registered, so a redirect must also squash the one stale instruction IMEM presents after the redirect; this block owns that bubble.

Parameters:
- REDIRECT_BUBBLES, 1, cycles of id_nop_sel after a redirect (1..3)
- CNT_W, 32, width of performance counters (optional feature only)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- id_rs1  in  5  source reg 1 of instruction in ID
- id_rs2  in  5  source reg 2 of instruction in ID
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_rd  in  5  destination reg of instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_branch_taken  in  1  EX resolved taken branch/jal/jalr (redirect)
- ex_mdu_start  in  1  EX instruction is a MUL/DIV op starting this cycle
- mdu_done  in  1  MDU result valid this cycle
- pc_en  out  1  PC register update enable
- if_id_en  out  1  IF/ID pipeline_en
- if_id_flush  out  1  IF/ID pipeline_flush
- id_nop_sel  out  1  force NOP into decode (squash stale IMEM word)
- id_ex_en  out  1  ID/EX enable
- id_ex_flush  out  1  ID/EX bubble insert
- ex_mem_flush  out  1  EX/MEM bubble insert
- mdu_busy  out  1  high while in MDU_WAIT
- stall_cnt  out  CNT_W  stall cycles (optional)
- flush_cnt  out  CNT_W  redirect events (optional)

Behaviour:
- All outputs are combinational from state and inputs. Defaults: enables=1, flushes/nop_sel=0.
- Reset: state=RUN, bubble counter=0, counters=0. During rst, enables=0, flushes=0, id_nop_sel=1, mdu_busy=0.
- States: RUN, REDIR, MDU_WAIT. Priority within a cycle: redirect > MDU > load-use.
- load_use = ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- RUN + ex_branch_taken: same cycle if_id_flush=1, id_ex_flush=1, enables stay 1 (PC takes target). Load accepts redirect-cycle load_use is ignored (wrong-path ID). Next: REDIR, bubble counter=REDIRECT_BUBBLES.
- REDIR: id_nop_sel=1, id_ex_flush=1, counter decrements each cycle; RUN when it reaches 1→0. Inputs ex_branch_taken/ex_mdu_start cannot be valid (EX holds bubbles) and are ignored.
- RUN + ex_mdu_start & !mdu_done: same cycle pc_en=0, if_id_en=0, id_ex_en=0, ex_mem_flush=1. Next: MDU_WAIT.
- RUN + ex_mdu_start & mdu_done (single-cycle op): no stall, stay RUN.
- MDU_WAIT: pc_en=if_id_en=id_ex_en=0, ex_mem_flush=1, mdu_busy=1. On mdu_done: all enables=1, ex_mem_flush=0 that cycle, next RUN. load_use is not evaluated in MDU_WAIT; it is evaluated in the following RUN cycle.
- RUN + load_use (no redirect/MDU): pc_en=0, if_id_en=0, id_ex_flush=1 for exactly that cycle. The load advances to MEM, so load_use clears next cycle. No state change.
- rst asserted mid-MDU_WAIT or mid-REDIR: immediate return to RUN; no pending stall survives.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: stall_cnt increments each cycle pc_en=0 outside reset. flush_cnt increments on each RUN→REDIR transition. Both wrap at 2^CNT_W.
- Undefined: no counter flops; stall_cnt and flush_cnt tied to 0.

Test Plan:
- Load x5 in EX (ex_mem_read=1, ex_rd=5), ID reads rs2=5 with use_rs2=1 → one cycle pc_en=0, if_id_en=0, id_ex_flush=1; next cycle all nominal.
- Same with ex_rd=0, or with id_use_rs1=0 and id_rs1=5 → no stall.
- ex_branch_taken pulse with REDIRECT_BUBBLES=2 → cycle T: if_id_flush=1, id_ex_flush=1; T+1,T+2: id_nop_sel=1; T+3: RUN; flush_cnt=1.
- ex_branch_taken concurrent with load_use → redirect response only, pc_en stays 1.
- ex_mdu_start with mdu_done after 33 cycles → pc_en=0 for 33 cycles, mdu_busy=1 for 32, release on done cycle; stall_cnt=33. ex_mdu_start with mdu_done same cycle → no stall.
- rst pulse at 10th MDU_WAIT cycle → state RUN, mdu_busy=0, counters 0 after release.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard sequencer: load-use, redirect and MUL/DIV stalls/flushes for the 5-stage core.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_ctrl #(
    parameter int REDIRECT_BUBBLES = 1,
    parameter int CNT_W            = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             ex_mdu_start,
    input  logic             mdu_done,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_nop_sel,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        REDIR    = 2'd1,
        MDU_WAIT = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] bub_cnt, bub_cnt_nxt;
    logic       load_use;
    logic       redirect_evt;

    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_nop_sel   = 1'b0;
        id_ex_en     = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mdu_busy     = 1'b0;
        state_nxt    = state;
        bub_cnt_nxt  = bub_cnt;
        redirect_evt = 1'b0;

        if (rst) begin
            pc_en      = 1'b0;
            if_id_en   = 1'b0;
            id_ex_en   = 1'b0;
            id_nop_sel = 1'b1;
        end else begin
            unique case (state)
                RUN: begin
                    // Redirect wins: the ID instruction is wrong-path, so its load-use is moot.
                    if (ex_branch_taken) begin
                        if_id_flush  = 1'b1;
                        id_ex_flush  = 1'b1;
                        state_nxt    = REDIR;
                        bub_cnt_nxt  = 2'(REDIRECT_BUBBLES);
                        redirect_evt = 1'b1;
                    end else if (ex_mdu_start && !mdu_done) begin
                        pc_en        = 1'b0;
                        if_id_en     = 1'b0;
                        id_ex_en     = 1'b0;
                        ex_mem_flush = 1'b1;
                        state_nxt    = MDU_WAIT;
                    end else if (load_use) begin
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                end
                REDIR: begin
                    // Squash the stale IMEM word(s) registered before the target fetch.
                    id_nop_sel  = 1'b1;
                    id_ex_flush = 1'b1;
                    bub_cnt_nxt = bub_cnt - 2'd1;
                    if (bub_cnt <= 2'd1) begin
                        state_nxt = RUN;
                    end
                end
                MDU_WAIT: begin
                    if (mdu_done) begin
                        state_nxt = RUN;
                    end else begin
                        pc_en        = 1'b0;
                        if_id_en     = 1'b0;
                        id_ex_en     = 1'b0;
                        ex_mem_flush = 1'b1;
                        mdu_busy     = 1'b1;
                    end
                end
                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            bub_cnt <= '0;
        end else begin
            state   <= state_nxt;
            bub_cnt <= bub_cnt_nxt;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_en) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (redirect_evt) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl with REDIRECT_BUBBLES=2.
module tb_hazard_stall_ctrl;

    localparam int CW = 32;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // ctl = {pc_en, if_id_en, if_id_flush, id_nop_sel, id_ex_en, id_ex_flush, ex_mem_flush, mdu_busy}
    localparam logic [7:0] C_NOM   = 8'b1100_1000;
    localparam logic [7:0] C_RST   = 8'b0001_0000;
    localparam logic [7:0] C_LU    = 8'b0000_1100;
    localparam logic [7:0] C_BR    = 8'b1110_1100;
    localparam logic [7:0] C_REDIR = 8'b1101_1100;
    localparam logic [7:0] C_MDU0  = 8'b0000_0010;
    localparam logic [7:0] C_MDUW  = 8'b0000_0011;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken, ex_mdu_start, mdu_done;
    logic          pc_en, if_id_en, if_id_flush, id_nop_sel, id_ex_en, id_ex_flush, ex_mem_flush, mdu_busy;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic [7:0]    ctl;

    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] exp_stall = '0;
    logic [CW-1:0] exp_flush = '0;

    assign ctl = {pc_en, if_id_en, if_id_flush, id_nop_sel, id_ex_en, id_ex_flush, ex_mem_flush, mdu_busy};

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.REDIRECT_BUBBLES(2), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .ex_mdu_start(ex_mdu_start), .mdu_done(mdu_done),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_nop_sel(id_nop_sel),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
        .mdu_busy(mdu_busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic idle_inputs();
        id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rd = '0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
        ex_mdu_start = 1'b0; mdu_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        @(negedge clk); #1;
        checks++;
        if (ctl !== C_RST) begin errors++; $display("FAIL reset_ctl got %b want %b", ctl, C_RST); end
        checks++;
        if (stall_cnt !== '0 || flush_cnt !== '0) begin
            errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0", stall_cnt, flush_cnt);
        end
        @(negedge clk); rst = 1'b0; #1;
        checks++;
        if (ctl !== C_NOM) begin errors++; $display("FAIL post_reset_ctl got %b want %b", ctl, C_NOM); end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1; #1;
        checks++;
        if (ctl !== C_LU) begin errors++; $display("FAIL lu_rs2 got %b want %b", ctl, C_LU); end
        exp_stall = exp_stall + 1;
        @(negedge clk); idle_inputs(); #1;
        checks++;
        if (ctl !== C_NOM) begin errors++; $display("FAIL lu_release got %b want %b", ctl, C_NOM); end
        @(negedge clk);
        ex_mem_read = 1'b1; ex_rd = 5'd17; id_rs1 = 5'd17; id_use_rs1 = 1'b1; #1;
        checks++;
        if (ctl !== C_LU) begin errors++; $display("FAIL lu_rs1 got %b want %b", ctl, C_LU); end
        exp_stall = exp_stall + 1;
        @(negedge clk); idle_inputs(); #1;
        checks++;
        if (stall_cnt !== (PERF ? exp_stall : '0)) begin
            errors++; $display("FAIL lu_stall_cnt got %0d want %0d", stall_cnt, PERF ? exp_stall : '0);
        end
    endtask

    task automatic test_no_stall();
        @(negedge clk);
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; id_use_rs2 = 1'b1; #1;
        checks++;
        if (ctl !== C_NOM) begin errors++; $display("FAIL x0_no_stall got %b want %b", ctl, C_NOM); end
        @(negedge clk);
        idle_inputs(); ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b0; #1;
        checks++;
        if (ctl !== C_NOM) begin errors++; $display("FAIL unused_rs1 got %b want %b", ctl, C_NOM); end
        @(negedge clk);
        idle_inputs(); ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1; #1;
        checks++;
        if (ctl !== C_NOM) begin errors++; $display("FAIL not_load got %b want %b", ctl, C_NOM); end
        @(negedge clk); idle_inputs();
    endtask

    task automatic test_redirect();
        ex_branch_taken = 1'b1;
        ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_use_rs1 = 1'b1; #1;
        checks++;
        if (ctl !== C_BR) begin errors++; $display("FAIL br_over_lu got %b want %b", ctl, C_BR); end
        exp_flush = exp_flush + 1;
        @(negedge clk); idle_inputs(); #1;
        checks++;
        if (ctl !== C_REDIR) begin errors++; $display("FAIL redir_t1 got %b want %b", ctl, C_REDIR); end
        checks++;
        if (flush_cnt !== (PERF ? exp_flush : '0)) begin
            errors++; $display("FAIL flush_cnt got %0d want %0d", flush_cnt, PERF ? exp_flush : '0);
        end
        @(negedge clk); ex_branch_taken = 1'b1; ex_mdu_start = 1'b1; #1;
        checks++;
        if (ctl !== C_REDIR) begin errors++; $display("FAIL redir_t2 got %b want %b", ctl, C_REDIR); end
        @(negedge clk); idle_inputs(); #1;
        checks++;
        if (ctl !== C_NOM) begin errors++; $display("FAIL redir_t3 got %b want %b", ctl, C_NOM); end
        @(negedge clk); #1;
        checks++;
        if (flush_cnt !== (PERF ? exp_flush : '0)) begin
            errors++; $display("FAIL flush_cnt_hold got %0d want %0d", flush_cnt, PERF ? exp_flush : '0);
        end
    endtask

    task automatic test_mdu_long();
        @(negedge clk); ex_mdu_start = 1'b1; #1;
        checks++;
        if (ctl !== C_MDU0) begin errors++; $display("FAIL mdu_start got %b want %b", ctl, C_MDU0); end
        exp_stall = exp_stall + 1;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk); ex_mdu_start = 1'b0; #1;
            checks++;
            if (ctl !== C_MDUW) begin errors++; $display("FAIL mdu_wait%0d got %b want %b", i, ctl, C_MDUW); end
            exp_stall = exp_stall + 1;
        end
        @(negedge clk); mdu_done = 1'b1; #1;
        checks++;
        if (ctl !== C_NOM) begin errors++; $display("FAIL mdu_done got %b want %b", ctl, C_NOM); end
        @(negedge clk); mdu_done = 1'b0; #1;
        checks++;
        if (ctl !== C_NOM) begin errors++; $display("FAIL mdu_after got %b want %b", ctl, C_NOM); end
        checks++;
        if (stall_cnt !== (PERF ? exp_stall : '0)) begin
            errors++; $display("FAIL mdu_stall_cnt got %0d want %0d", stall_cnt, PERF ? exp_stall : '0);
        end
    endtask

    task automatic test_mdu_single();
        @(negedge clk); ex_mdu_start = 1'b1; mdu_done = 1'b1; #1;
        checks++;
        if (ctl !== C_NOM) begin errors++; $display("FAIL mdu_single got %b want %b", ctl, C_NOM); end
        @(negedge clk); idle_inputs(); #1;
        checks++;
        if (ctl !== C_NOM) begin errors++; $display("FAIL mdu_single_next got %b want %b", ctl, C_NOM); end
    endtask

    task automatic test_priority();
        @(negedge clk); ex_branch_taken = 1'b1; ex_mdu_start = 1'b1; #1;
        checks++;
        if (ctl !== C_BR) begin errors++; $display("FAIL br_over_mdu got %b want %b", ctl, C_BR); end
        exp_flush = exp_flush + 1;
        @(negedge clk); idle_inputs(); #1;
        checks++;
        if (ctl !== C_REDIR) begin errors++; $display("FAIL prio_redir got %b want %b", ctl, C_REDIR); end
        @(negedge clk); @(negedge clk); #1;
        checks++;
        if (flush_cnt !== (PERF ? exp_flush : '0)) begin
            errors++; $display("FAIL prio_flush_cnt got %0d want %0d", flush_cnt, PERF ? exp_flush : '0);
        end
    endtask

    task automatic test_reset_mid_mdu();
        @(negedge clk); ex_mdu_start = 1'b1; #1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk); ex_mdu_start = 1'b0;
        end
        #1;
        checks++;
        if (ctl !== C_MDUW) begin errors++; $display("FAIL mdu_wait10 got %b want %b", ctl, C_MDUW); end
        rst = 1'b1; #1;
        checks++;
        if (ctl !== C_RST) begin errors++; $display("FAIL mid_rst_ctl got %b want %b", ctl, C_RST); end
        @(negedge clk); rst = 1'b0; #1;
        exp_stall = '0; exp_flush = '0;
        checks++;
        if (ctl !== C_NOM) begin errors++; $display("FAIL mid_rst_release got %b want %b", ctl, C_NOM); end
        checks++;
        if (stall_cnt !== '0 || flush_cnt !== '0) begin
            errors++; $display("FAIL mid_rst_cnt got %0d/%0d want 0/0", stall_cnt, flush_cnt);
        end
        @(negedge clk); #1;
        checks++;
        if (ctl !== C_NOM) begin errors++; $display("FAIL mid_rst_run got %b want %b", ctl, C_NOM); end
    endtask

    task automatic test_reset_mid_redir();
        @(negedge clk); ex_branch_taken = 1'b1;
        @(negedge clk); ex_branch_taken = 1'b0; #1;
        checks++;
        if (ctl !== C_REDIR) begin errors++; $display("FAIL redir_pre_rst got %b want %b", ctl, C_REDIR); end
        rst = 1'b1;
        @(negedge clk); rst = 1'b0; #1;
        checks++;
        if (ctl !== C_NOM) begin errors++; $display("FAIL redir_rst_release got %b want %b", ctl, C_NOM); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_stall();
        test_redirect();
        test_mdu_long();
        test_mdu_single();
        test_priority();
        test_reset_mid_mdu();
        test_reset_mid_redir();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
